// File: rtl/pwm_ramp_sequencer_if.sv
// Command channel of pwm_ramp_sequencer: per-channel duty target and slew step
// offered with a valid/ready handshake.
interface pwm_ramp_sequencer_if #(
    parameter int CH_W = 2
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic [CH_W-1:0] cmd_chan;
    logic [7:0]      cmd_target;
    logic [7:0]      cmd_step;

    modport master (output cmd_valid, output cmd_chan, output cmd_target, output cmd_step,
                    input  cmd_ready);
    modport slave  (input  cmd_valid, input  cmd_chan, input  cmd_target, input  cmd_step,
                    output cmd_ready);
endinterface

// File: rtl/pwm_ramp_sequencer.sv
// Per-frame duty slew sequencer feeding a bank of 8-bit PWM channels.
// Optional emergency stop input is compiled in when PWM_ESTOP_EN is defined.
module pwm_ramp_sequencer #(
    parameter int NUM_CH   = 4,
    parameter int TICK_DIV = 256,
    parameter int DUTY_MAX = 255,
    parameter int CH_W     = 2
) (
    input  logic                clk,
    input  logic                reset_n,
`ifdef PWM_ESTOP_EN
    input  logic                estop,
`endif
    pwm_ramp_sequencer_if.slave cmd,
    output logic [NUM_CH*8-1:0] duty_flat,
    output logic                busy,
    output logic [NUM_CH-1:0]   arrived,
    output logic                cmd_err,
    output logic                frame_tick
);
    localparam int              TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int              CHW1      = CH_W + 1;
    localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [TW-1:0]   TICK_PRE  = TW'(TICK_DIV - 2);
    localparam logic [CH_W:0]   NUM_CH_L  = CHW1'(NUM_CH);
    localparam logic [CH_W-1:0] LAST_IDX  = CH_W'(NUM_CH - 1);
    localparam logic [7:0]      DMAX      = 8'(DUTY_MAX);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SCAN = 1'b1} state_t;

    state_t          r_state, w_state_nxt;
    logic [CH_W-1:0] r_idx, w_idx_nxt;
    logic [TW-1:0]   r_tick;
    logic            r_frame_tick;
    logic [7:0]      r_duty   [NUM_CH];
    logic [7:0]      r_target [NUM_CH];
    logic [7:0]      r_step   [NUM_CH];
    logic [7:0]      w_duty_nxt [NUM_CH];
    logic [8:0]      w_diff     [NUM_CH];
    logic [NUM_CH-1:0] r_arrived;
    logic            r_cmd_err;
    logic            w_estop, w_ready, w_accept, w_chan_ok;
    logic [7:0]      w_tgt_clamp, w_step_fix;

`ifdef PWM_ESTOP_EN
    assign w_estop = estop;
`else
    assign w_estop = 1'b0;
`endif

    assign w_ready        = (r_state == ST_IDLE) && !w_estop;
    assign cmd.cmd_ready  = w_ready;
    assign w_accept       = cmd.cmd_valid && w_ready;
    assign w_chan_ok      = ({1'b0, cmd.cmd_chan} < NUM_CH_L);
    assign w_tgt_clamp    = (cmd.cmd_target > DMAX) ? DMAX : cmd.cmd_target;
    assign w_step_fix     = (cmd.cmd_step == 8'd0) ? 8'd1 : cmd.cmd_step;
    assign frame_tick     = r_frame_tick;
    assign arrived        = r_arrived;
    assign cmd_err        = r_cmd_err;

    // Free-running frame counter; the strobe is registered one count early to line up with TICK_DIV-1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tick       <= {TW{1'b0}};
            r_frame_tick <= 1'b0;
        end else begin
            r_tick       <= (r_tick == TICK_LAST) ? {TW{1'b0}} : r_tick + {{(TW-1){1'b0}}, 1'b1};
            r_frame_tick <= (r_tick == TICK_PRE);
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_idx   <= {CH_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Next state: one frame strobe starts a scan that visits each channel once.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        if (w_estop) begin
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = {CH_W{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_frame_tick) begin
                        w_state_nxt = ST_SCAN;
                        w_idx_nxt   = {CH_W{1'b0}};
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_SCAN: begin
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt = ST_IDLE;
                        w_idx_nxt   = {CH_W{1'b0}};
                    end else begin
                        w_idx_nxt   = r_idx + {{(CH_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_idx_nxt   = {CH_W{1'b0}};
                end
            endcase
        end
    end

    // Slew candidate per channel; the 9-bit distance keeps the step from overshooting or wrapping.
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            w_diff[k]     = 9'd0;
            w_duty_nxt[k] = r_duty[k];
            if (r_duty[k] < r_target[k]) begin
                w_diff[k]     = {1'b0, r_target[k]} - {1'b0, r_duty[k]};
                w_duty_nxt[k] = (w_diff[k] <= {1'b0, r_step[k]}) ? r_target[k] : r_duty[k] + r_step[k];
            end else if (r_duty[k] > r_target[k]) begin
                w_diff[k]     = {1'b0, r_duty[k]} - {1'b0, r_target[k]};
                w_duty_nxt[k] = (w_diff[k] <= {1'b0, r_step[k]}) ? r_target[k] : r_duty[k] - r_step[k];
            end else begin
                w_duty_nxt[k] = r_duty[k];
            end
        end
    end

    // Channel registers: estop wins, then the scan update, then command capture (only in IDLE).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_CH; k++) begin
                r_duty[k]   <= 8'd0;
                r_target[k] <= 8'd0;
                r_step[k]   <= 8'd1;
            end
            r_arrived <= {NUM_CH{1'b0}};
            r_cmd_err <= 1'b0;
        end else begin
            r_arrived <= {NUM_CH{1'b0}};
            r_cmd_err <= 1'b0;
            if (w_estop) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    r_duty[k]   <= 8'd0;
                    r_target[k] <= 8'd0;
                end
            end else if (r_state == ST_SCAN) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    if (r_idx == CH_W'(k)) begin
                        r_duty[k]    <= w_duty_nxt[k];
                        r_arrived[k] <= (r_duty[k] != r_target[k]) && (w_duty_nxt[k] == r_target[k]);
                    end
                end
            end else if (w_accept) begin
                if (w_chan_ok) begin
                    for (int k = 0; k < NUM_CH; k++) begin
                        if (cmd.cmd_chan == CH_W'(k)) begin
                            r_target[k] <= w_tgt_clamp;
                            r_step[k]   <= w_step_fix;
                        end
                    end
                end else begin
                    r_cmd_err <= 1'b1;
                end
            end
        end
    end

    // Output packing and any-channel-moving flag.
    always_comb begin
        duty_flat = {(NUM_CH*8){1'b0}};
        busy      = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            duty_flat[8*k +: 8] = r_duty[k];
            busy                = busy | (r_duty[k] != r_target[k]);
        end
    end
endmodule

// File: doc/pwm_ramp_sequencer.md
Name: pwm_ramp_sequencer

Overview:
Multi-channel duty-cycle sequencer that drives the duty_cycle inputs of a bank of pwm_module instances, one per arm joint. A host FSM or CPU issues per-channel target and slew-step commands over a valid/ready handshake. Once per PWM frame, the block slews each channel's duty toward its target, so servos move smoothly and duty only changes on frame boundaries. Sits between the motion-command logic and the PWM bank.

Parameters:
NUM_CH, 4, number of PWM channels; must satisfy 1 <= NUM_CH < TICK_DIV.
TICK_DIV, 256, clock cycles per update frame; matches the 8-bit pwm_module counter period.
DUTY_MAX, 255, upper clamp applied to every target (0..255).
CH_W, 2, width of cmd_chan; must satisfy 2**CH_W >= NUM_CH.

Ports:
clk  in  1  system clock; all logic rising-edge.
reset_n  in  1  asynchronous active-low reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  high when the block can accept a command (IDLE state).
cmd_chan  in  CH_W  target channel index.
cmd_target  in  8  requested duty target.
cmd_step  in  8  per-frame slew step; 0 is treated as 1.
duty_flat  out  NUM_CH*8  registered duty per channel; channel k occupies bits [8k+7:8k].
busy  out  1  high while any channel's duty differs from its target.
arrived  out  NUM_CH  one-cycle pulse when a channel reaches its target during an update.
cmd_err  out  1  one-cycle pulse when a command names a channel >= NUM_CH.
frame_tick  out  1  one-cycle strobe at each frame boundary.

Behaviour:
- Reset (async, immediate, including mid-ramp):
  - all duty = 0, all targets = 0, all steps = 1.
  - tick counter = 0; state = IDLE.
  - arrived = 0, cmd_err = 0, frame_tick = 0.
  - So cmd_ready = 1 and busy = 0 after reset.
- Tick counter:
  - counts 0..TICK_DIV-1, then wraps to 0.
  - frame_tick = 1 for exactly the one cycle where counter == TICK_DIV-1.
  - Runs freely in all states.
- Command accept: occurs on a rising edge with cmd_valid && cmd_ready.
  - If cmd_chan < NUM_CH: target[chan] <= min(cmd_target, DUTY_MAX); step[chan] <= max(cmd_step, 1).
  - If cmd_chan >= NUM_CH: command is consumed; cmd_err pulses the next cycle; no state changes.
  - cmd_ready is combinational: 1 in IDLE, 0 in SCAN.
- FSM IDLE:
  - On frame_tick, go to SCAN with idx = 0.
  - If a handshake and frame_tick coincide, the command is accepted and the new target is used in the scan that follows.
- FSM SCAN: processes one channel per cycle, idx = 0..NUM_CH-1, then returns to IDLE.
  - Total SCAN time is NUM_CH cycles, so a frame_tick can never occur during SCAN.
  - Per-channel update, using 9-bit difference arithmetic (no wrap):
    - if duty < target: duty <= (target - duty <= step) ? target : duty + step.
    - if duty > target: duty <= (duty - target <= step) ? target : duty - step.
    - if equal: no change.
  - arrived[idx] pulses in the cycle after an update makes duty == target, and only if duty was unequal before that update.
- busy: combinational OR over channels of (duty != target).
- Latency: a command accepted at cycle t first changes channel k's duty (k+1) cycles after the first frame_tick at or after t.
- A new command may retarget a channel mid-ramp; the ramp continues from the current duty at the new step.
- Duty outputs change at most once per frame per channel, so pwm_module always sees glitch-free updates.

Optional Feature:
Macro: PWM_ESTOP_EN.
- Defined:
  - adds input port estop (1 bit, active-high, synchronous to clk).
  - While estop = 1: next edge forces all duty and targets to 0, state to IDLE, and cmd_ready to 0; no arrived pulses are generated.
  - Normal operation resumes on the first cycle after estop deasserts.
- Undefined: no estop port and no related logic.

Test Plan:
1. Reset asserted mid-ramp -> duty_flat = 0 immediately; after release, cmd_ready = 1 and busy = 0.
2. ch0 target 10, step 3 -> ch0 duty 3, 6, 9, 10 on successive frames; arrived[0] pulses once after the 10; busy falls at the same time.
3. DUTY_MAX = 200; ch1 target 250, step 0 -> target clamps to 200; duty rises by 1 per frame.
4. ch2 at 10, then target 0, step 4 -> 6, 2, 0; arrived[2] pulses once; ch0, ch1 and ch3 are unchanged.
5. NUM_CH = 4, cmd_chan = 5 (CH_W = 3) -> cmd_err pulses one cycle; duty_flat and targets are unchanged.
6. PWM_ESTOP_EN defined; estop pulsed mid-ramp with duty at 40 -> all duty = 0 the next cycle; cmd_ready = 0 while estop is high; ramps resume only after new commands.
